// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the dmem arbiter.
// FSM state encoding, port indices, read-latency counter width and a
// small helper that turns a port index into a one-hot port vector.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;

  // RD_LAT ranges over 1..4, so the countdown needs 3 bits.
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

  function automatic logic [1:0] port_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester ports and the dmem-facing bus.
// The arbiter takes the slave view; the environment (requesters plus the
// memory itself) takes the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_wren;
  logic [DATA_W-1:0]   mem_q;

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output gnt, rvalid, rdata, busy, mem_address, mem_data, mem_wren
  );

  modport master (
    output req, we, addr, wdata, mem_q,
    input  gnt, rvalid, rdata, busy, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational port selection for the dmem arbiter.
// Default build is round-robin: on contention the port that did not win
// last time is chosen. Defining DMEM_ARB_FIXED_PRIO_EN makes port 0 win
// every contention (port 1 can then starve).
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       sel_o,
  output logic       any_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // History is still tracked by the caller but plays no part here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Single requester wins outright; only contention needs a policy.
  always_comb begin
    any_o = |req_i;
    sel_o = 1'(PORT_CPU);
    if (req_i == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      sel_o = 1'(PORT_CPU);
`else
      sel_o = ~last_grant_i;
`endif
    end else if (req_i[PORT_AUX]) begin
      sel_o = 1'(PORT_AUX);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous-read dmem between the
// CPU load/store unit (port 0) and an auxiliary master (port 1).
// One transaction at a time: IDLE -> ACCESS (-> WAIT -> RESP for reads).
// All dmem-facing signals and handshake outputs are registered.
// Optional macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority to port 0,
// handled inside dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  arb_state_e        state_q;
  logic              last_grant_q;
  logic              sel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wren_q;

  logic              sel_d;
  logic              any_d;
  logic [ADDR_W-1:0] port_addr  [2];
  logic [DATA_W-1:0] port_wdata [2];

  // Split the packed per-port buses into indexable per-port words.
  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign port_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
    assign port_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
  end

  dmem_arb_pick u_pick (
    .req_i        (bus.req),
    .last_grant_i (last_grant_q),
    .sel_o        (sel_d),
    .any_o        (any_d)
  );

  // Transaction sequencer: requests are only looked at in IDLE, so a
  // requester simply holds its request until it sees gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'(PORT_AUX);
      sel_q         <= 1'b0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
    end else begin
      // Pulses default low; address/data hold their last values.
      gnt_q      <= '0;
      rvalid_q   <= '0;
      mem_wren_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_d) begin
            mem_address_q <= port_addr[sel_d];
            mem_data_q    <= port_wdata[sel_d];
            mem_wren_q    <= bus.we[sel_d];
            gnt_q         <= port_onehot(sel_d);
            last_grant_q  <= sel_d;
            sel_q         <= sel_d;
            busy_q        <= 1'b1;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          // dmem commits a write, or samples the read address, at the
          // edge that ends this state.
          if (mem_wren_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rdata_q  <= bus.mem_q;
            rvalid_q <= port_onehot(sel_q);
            state_q  <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Two DUTs (RD_LAT = 1 and RD_LAT = 3), each with a behavioural dmem.
// Directed table, hand-written corner sequences, then a randomized run
// checked cycle by cycle against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RL_A   = 1;
  localparam int RL_B   = 3;
  localparam int N_RAND = 300;
  localparam int E_SZ   = N_RAND + 80;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, mem_init;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL_A)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL_B)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b));

  // Behavioural dmem for each DUT: write on edge, read pipelined RD_LAT deep.
  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] q_a   [RL_A];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] q_b   [RL_B];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus_a.mem_wren) begin
      mem_a[bus_a.mem_address[5:0]] <= bus_a.mem_data;
    end
    q_a[0] <= mem_a[bus_a.mem_address[5:0]];
    for (int k = 1; k < RL_A; k++) q_a[k] <= q_a[k-1];
  end
  assign bus_a.mem_q = q_a[RL_A-1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus_b.mem_wren) begin
      mem_b[bus_b.mem_address[5:0]] <= bus_b.mem_data;
    end
    q_b[0] <= mem_b[bus_b.mem_address[5:0]];
    for (int k = 1; k < RL_B; k++) q_b[k] <= q_b[k-1];
  end
  assign bus_b.mem_q = q_b[RL_B-1];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pre(input int i);
    return 32'hA000_0000 + i[31:0];
  endfunction

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [5:0]  a0;
    logic [5:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          first;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [1:0] r, input logic [1:0] w,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input int f, input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.name = n; v.req = r; v.we = w; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.first = f; v.rd0 = r0; v.rd1 = r1;
    return v;
  endfunction

  // Issue one table entry on DUT A from IDLE and watch it to completion.
  task automatic run_vec(input vec_t v);
    logic [1:0] pend, rd_exp;
    int seen0, seen1, first_port, first_cyc, rv_cyc, p;
    bit done;
    bus_a.we    = v.we;
    bus_a.addr  = {26'd0, v.a1, 26'd0, v.a0};
    bus_a.wdata = {v.d1, v.d0};
    bus_a.req   = v.req;
    pend = v.req; rd_exp = v.req & ~v.we;
    seen0 = 0; seen1 = 0; first_port = -1; first_cyc = 0; rv_cyc = 0; done = 1'b0;
    for (int t = 1; t <= 30 && !done; t++) begin
      @(posedge clk); #1;
      if (bus_a.gnt != 2'b00) begin
        chk({v.name, " gnt_onehot"}, bus_a.gnt != 2'b11, 1);
        p = bus_a.gnt[1] ? 1 : 0;
        if (first_port < 0) begin first_port = p; first_cyc = t; end
        pend[p] = 1'b0;
        bus_a.req[p] = 1'b0;
      end
      if (bus_a.rvalid != 2'b00) begin
        chk({v.name, " rvalid_onehot"}, bus_a.rvalid != 2'b11, 1);
        p = bus_a.rvalid[1] ? 1 : 0;
        if (p == 1) seen1++; else seen0++;
        chk($sformatf("%s rdata p%0d", v.name, p), bus_a.rdata, (p == 1) ? v.rd1 : v.rd0);
        if (p == first_port) rv_cyc = t;
      end
      if (pend == 2'b00 && seen0 == int'(rd_exp[0]) && seen1 == int'(rd_exp[1]) && !bus_a.busy)
        done = 1'b1;
    end
    bus_a.req = 2'b00;
    chk({v.name, " completes"}, done, 1);
    chk({v.name, " first_port"}, first_port, v.first);
    chk({v.name, " gnt_latency"}, first_cyc, 1);
    chk({v.name, " rvalid_count p0"}, seen0, int'(rd_exp[0]));
    chk({v.name, " rvalid_count p1"}, seen1, int'(rd_exp[1]));
    if (v.req != 2'b11 && rd_exp != 2'b00)
      chk({v.name, " rvalid_latency"}, rv_cyc, 2 + RL_A);
  endtask

  // Bounded wait for DUT A to return to IDLE.
  task automatic drain_a(input string name);
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 20 && !idle; t++) begin
      @(posedge clk); #1;
      if (!bus_a.busy) idle = 1'b1;
    end
    chk({name, " drain"}, idle, 1);
  endtask

  vec_t vecs [7];

  // Expected-behaviour schedule for the random run.
  logic [1:0]  e_gnt  [E_SZ];
  logic [1:0]  e_rv   [E_SZ];
  logic [31:0] e_rd   [E_SZ];
  logic        e_busy [E_SZ];
  logic        e_wren [E_SZ];
  logic [31:0] e_addr [E_SZ];
  logic [31:0] e_data [E_SZ];
  logic [31:0] ref_mem [64];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rv_at, gnt_at, busy_n, free_c, sel;
    logic lg;
    logic [1:0]  r_req, r_we;
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];

    rst_a_n = 1'b0; rst_b_n = 1'b0; mem_init = 1'b1;
    bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0;

    vecs[0] = mk("both_rd",   2'b11, 2'b00, 6'd0,  6'd3,  32'h0,  32'h0,        0,
                 pre(0), pre(3));
    vecs[1] = mk("p0_wr10",   2'b01, 2'b01, 6'd10, 6'd0,  32'hAB, 32'h0,        0,
                 32'h0, 32'h0);
    vecs[2] = mk("p0_rd10",   2'b01, 2'b00, 6'd10, 6'd0,  32'h0,  32'h0,        0,
                 32'hAB, 32'h0);
    vecs[3] = mk("same_addr", 2'b11, 2'b10, 6'd5,  6'd5,  32'h0,  32'h12345678,
                 FIXED ? 0 : 1, FIXED ? pre(5) : 32'h12345678, 32'h0);
    vecs[4] = mk("p1_rd10",   2'b10, 2'b00, 6'd0,  6'd10, 32'h0,  32'h0,        1,
                 32'h0, 32'hAB);
    vecs[5] = mk("both_wr",   2'b11, 2'b11, 6'd20, 6'd21, 32'h11, 32'h22,       0,
                 32'h0, 32'h0);
    vecs[6] = mk("both_rd2",  2'b11, 2'b00, 6'd20, 6'd21, 32'h0,  32'h0,        0,
                 32'h11, 32'h22);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a outputs", {bus_a.gnt, bus_a.rvalid, bus_a.rdata, bus_a.busy,
        bus_a.mem_address, bus_a.mem_data, bus_a.mem_wren}, 128'd0);
    chk("reset_b outputs", {bus_b.gnt, bus_b.rvalid, bus_b.rdata, bus_b.busy,
        bus_b.mem_address, bus_b.mem_data, bus_b.mem_wren}, 128'd0);
    mem_init = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both ports hold req for six grants.
    bus_a.we = 2'b00;
    bus_a.addr = {26'd0, 6'd3, 26'd0, 6'd0};
    bus_a.req = 2'b11;
    k = 0;
    for (int t = 0; t < 100 && k < 6; t++) begin
      @(posedge clk); #1;
      if (bus_a.rvalid != 2'b00)
        chk("alt rdata", bus_a.rdata, bus_a.rvalid[1] ? pre(3) : pre(0));
      if (bus_a.gnt != 2'b00) begin
        chk($sformatf("alt grant %0d", k), bus_a.gnt,
            (!FIXED && (k % 2 == 1)) ? 2'b10 : 2'b01);
        k++;
        if (k == 6) bus_a.req = 2'b00;
      end
    end
    bus_a.req = 2'b00;
    chk("alt grant count", k, 6);
    drain_a("alt");

    // Reset during WAIT of a port 1 read.
    bus_a.we = 2'b00;
    bus_a.addr = {26'd0, 6'd3, 32'd0};
    bus_a.req = 2'b10;
    @(posedge clk); #1;
    chk("rstmid gnt", bus_a.gnt, 2'b10);
    bus_a.req = 2'b00;
    @(posedge clk); #1;
    chk("rstmid busy in wait", bus_a.busy, 1);
    rst_a_n = 1'b0;
    #1;
    chk("rstmid outputs", {bus_a.gnt, bus_a.rvalid, bus_a.rdata, bus_a.busy,
        bus_a.mem_address, bus_a.mem_data, bus_a.mem_wren}, 128'd0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      chk($sformatf("rstmid no rvalid %0d", t), bus_a.rvalid, 2'b00);
    end
    run_vec(mk("post_rst_rd", 2'b01, 2'b00, 6'd3, 6'd0, 32'h0, 32'h0, 0, pre(3), 32'h0));

    // RD_LAT = 3 instance: single read timing.
    bus_b.we = 2'b00;
    bus_b.addr = {32'd0, 32'd7};
    bus_b.req = 2'b01;
    rv_at = 0; gnt_at = 0; busy_n = 0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      if (bus_b.gnt[0] && gnt_at == 0) begin gnt_at = t; bus_b.req = 2'b00; end
      if (bus_b.busy) busy_n++;
      if (bus_b.rvalid != 2'b00) begin
        rv_at = t;
        chk("rl3 rvalid port", bus_b.rvalid, 2'b01);
        chk("rl3 rdata", bus_b.rdata, pre(7));
      end
    end
    bus_b.req = 2'b00;
    chk("rl3 gnt latency", gnt_at, 1);
    chk("rl3 rvalid latency", rv_at, 2 + RL_B);
    chk("rl3 busy cycles", busy_n, 5);

    // Randomized run on DUT A against the schedule model.
    for (int i = 0; i < E_SZ; i++) begin
      e_gnt[i] = '0; e_rv[i] = '0; e_rd[i] = '0; e_busy[i] = 1'b0;
      e_wren[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
    end
    for (int i = 0; i < 64; i++) ref_mem[i] = pre(i);
    r_req = 2'b00; r_we = 2'b00;
    r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
    bus_a.req = 2'b00;
    rst_a_n = 1'b0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    free_c = 0; lg = 1'b1;
    for (int c = 0; c < N_RAND + 40; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rand c%0d gnt", c), bus_a.gnt, e_gnt[c]);
      chk($sformatf("rand c%0d rvalid", c), bus_a.rvalid, e_rv[c]);
      chk($sformatf("rand c%0d busy", c), bus_a.busy, e_busy[c]);
      chk($sformatf("rand c%0d mem_wren", c), bus_a.mem_wren, e_wren[c]);
      if (e_rv[c] != 2'b00)
        chk($sformatf("rand c%0d rdata", c), bus_a.rdata, e_rd[c]);
      if (e_gnt[c] != 2'b00) begin
        chk($sformatf("rand c%0d mem_address", c), bus_a.mem_address, e_addr[c]);
        chk($sformatf("rand c%0d mem_data", c), bus_a.mem_data, e_data[c]);
      end
      // Requesters: a granted request is consumed; idle ports may start a new one.
      for (int p = 0; p < 2; p++) begin
        if (e_gnt[c][p]) r_req[p] = 1'b0;
        if (!r_req[p] && c < N_RAND && $urandom_range(0, 2) == 0) begin
          r_req[p]   = 1'b1;
          r_we[p]    = 1'($urandom_range(0, 1));
          r_addr[p]  = 32'(32 + $urandom_range(0, 15));
          r_wdata[p] = $urandom;
        end
      end
      bus_a.req   = r_req;
      bus_a.we    = r_we;
      bus_a.addr  = {r_addr[1], r_addr[0]};
      bus_a.wdata = {r_wdata[1], r_wdata[0]};
      // Model: when the arbiter is free, the chosen request is issued next cycle.
      if (c >= free_c && r_req != 2'b00) begin
        if (r_req == 2'b11) sel = FIXED ? 0 : (lg ? 0 : 1);
        else sel = r_req[1] ? 1 : 0;
        lg = (sel == 1);
        e_gnt[c+1]  = (sel == 1) ? 2'b10 : 2'b01;
        e_busy[c+1] = 1'b1;
        e_addr[c+1] = r_addr[sel];
        e_data[c+1] = r_wdata[sel];
        if (r_we[sel]) begin
          e_wren[c+1] = 1'b1;
          ref_mem[r_addr[sel][5:0]] = r_wdata[sel];
          free_c = c + 2;
        end else begin
          for (int j = 2; j <= 2 + RL_A; j++) e_busy[c+j] = 1'b1;
          e_rv[c+2+RL_A] = (sel == 1) ? 2'b10 : 2'b01;
          e_rd[c+2+RL_A] = ref_mem[r_addr[sel][5:0]];
          free_c = c + 3 + RL_A;
        end
      end
    end
    chk("rand all requests served", r_req, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
